truth_table_sweeper: RTL and testbench

- Sequential self-checking stimulus engine for small combinational Boolean blocks.
- On `start`, drives every input combination of an N_IN-input device under test (DUT) in ascending binary order.
- Waits SETTLE cycles per vector, samples the DUT output and compares it against a parameterised expected truth table.
- Accumulates a failure count and captures the first failing vector.
- Generalises single-vector, fixed 3-input, delay-and-compare checking into an exhaustive, width-parameterised, synthesizable checker that sits beside the DUT.

---
 rtl/truth_table_sweeper_if.sv | 24 ++
 rtl/truth_table_sweeper.sv | 76 +++++++
 tb/tb_truth_table_sweeper.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: start/DUT-sample inputs and result outputs of the sweeper.
//   master: drives start and dut_f, observes stim and results.
//   slave : the sweeper itself.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            dut_f;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;
    modport master (
        output start, dut_f,
        input  stim, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
    );
    modport slave (
        input  start, dut_f,
        output stim, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive truth-table checker for an N_IN-input combinational block.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : start/dut_f in; stim, busy, done, pass, fail_count, first_fail_vec, first_fail_valid out
module truth_table_sweeper #(
    parameter int                  N_IN     = 3,
    parameter int                  SETTLE   = 5,
    parameter logic [2**N_IN-1:0]  EXPECTED = 8'b0110_1001
) (
    input logic               clk,
    input logic               reset,
    truth_table_sweeper_if.slave bus
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST = '1;
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SETTLE_WAIT = 2'd1;
    localparam logic [1:0] DONE        = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          at_sample;
    logic          mismatch;
    logic [N_IN:0] fc_next;

    always_comb begin
        at_sample = cnt == CW'(SETTLE - 1);
        mismatch  = bus.dut_f != EXPECTED[bus.stim];
        fc_next   = bus.fail_count + (N_IN + 1)'(mismatch);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            bus.stim             <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.pass             <= 1'b0;
            bus.fail_count       <= '0;
            bus.first_fail_vec   <= '0;
            bus.first_fail_valid <= 1'b0;
        end else if (state != SETTLE_WAIT) begin
            // IDLE and DONE both accept start and hold results otherwise
            if (bus.start) begin
                state                <= SETTLE_WAIT;
                cnt                  <= '0;
                bus.stim             <= '0;
                bus.busy             <= 1'b1;
                bus.done             <= 1'b0;
                bus.pass             <= 1'b0;
                bus.fail_count       <= '0;
                bus.first_fail_vec   <= '0;
                bus.first_fail_valid <= 1'b0;
            end
        end else if (!at_sample) begin
            cnt <= cnt + CW'(1);
        end else begin
            bus.fail_count <= fc_next;
            if (mismatch && !bus.first_fail_valid) begin
                bus.first_fail_vec   <= bus.stim;
                bus.first_fail_valid <= 1'b1;
            end
            // all-ones is the terminal vector; stim is held there rather than wrapping
            if (bus.stim == LAST) begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.pass <= fc_next == '0;
            end else begin
                bus.stim <= bus.stim + N_IN'(1);
                cnt      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps of two sweeper instances checked against a timing model.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0]  EXP_A = 8'b0110_1001;
    localparam logic [15:0] EXP_B = 16'hFFFE;
    localparam int S_A = 5;
    localparam int S_B = 1;

    truth_table_sweeper_if #(.N_IN(3)) a_if ();
    truth_table_sweeper_if #(.N_IN(4)) b_if ();

    truth_table_sweeper dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    truth_table_sweeper #(.N_IN(4), .SETTLE(S_B), .EXPECTED(EXP_B)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    int n_chk = 0;
    int n_fail = 0;

    // DUT behaviours: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ideal except vector 4 returns 1
    function automatic logic dut_model(int mode, int k, logic [15:0] tt);
        logic [15:0] t;
        t = tt;
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return k == 4 ? 1'b1 : t[k];
            default: return t[k];
        endcase
    endfunction

    int   a_mode = 0;
    int   b_mode = 0;
    logic glitch = 1'b0;
    bit   glitch_en = 1'b0;

    assign a_if.dut_f = dut_model(a_mode, int'(a_if.stim), {8'h00, EXP_A}) ^ glitch;
    assign b_if.dut_f = dut_model(b_mode, int'(b_if.stim), EXP_B);

    // short pulses well clear of the rising edge
    always @(negedge clk) if (glitch_en) begin
        #1 glitch = 1'b1;
        #2 glitch = 1'b0;
    end

    // model state: whether a sweep has been started, cycles since the start edge, mode at start
    bit a_act = 0, b_act = 0;
    int a_t = 0, b_t = 0, a_sm = 0, b_sm = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_act = 0;
            b_act = 0;
        end else begin
            if (a_if.start && !(a_act && a_t < 8 * S_A)) begin
                a_act = 1; a_t = 0; a_sm = a_mode;
            end else if (a_act) a_t++;
            if (b_if.start && !(b_act && b_t < 16 * S_B)) begin
                b_act = 1; b_t = 0; b_sm = b_mode;
            end else if (b_act) b_t++;
        end
    end

    typedef struct {
        int stim;
        bit busy;
        bit done;
        bit pass;
        int fc;
        int ffv;
        bit ffvalid;
    } exp_t;

    // vector k is held for cycles [k*s, (k+1)*s) and judged at the edge ending that window
    function automatic exp_t model(int n, int s, logic [15:0] tt, int mode, bit act, int t);
        exp_t e;
        int last;
        logic [15:0] tv;
        tv = tt;
        e = '{default: 0};
        last = (1 << n) - 1;
        if (!act) return e;
        e.busy = t < (last + 1) * s;
        e.done = !e.busy;
        e.stim = t / s > last ? last : t / s;
        for (int k = 0; k <= last; k++)
            if ((k + 1) * s <= t && dut_model(mode, k, tt) != tv[k]) begin
                if (!e.ffvalid) begin
                    e.ffvalid = 1;
                    e.ffv = k;
                end
                e.fc++;
            end
        e.pass = e.done && e.fc == 0;
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    exp_t ea, eb;
    always @(negedge clk) begin
        ea = model(3, S_A, {8'h00, EXP_A}, a_sm, a_act, a_t);
        eb = model(4, S_B, EXP_B, b_sm, b_act, b_t);
        chk("a.stim", int'(a_if.stim), ea.stim);
        chk("a.busy", int'(a_if.busy), int'(ea.busy));
        chk("a.done", int'(a_if.done), int'(ea.done));
        chk("a.pass", int'(a_if.pass), int'(ea.pass));
        chk("a.fail_count", int'(a_if.fail_count), ea.fc);
        chk("a.first_fail_vec", int'(a_if.first_fail_vec), ea.ffv);
        chk("a.first_fail_valid", int'(a_if.first_fail_valid), int'(ea.ffvalid));
        chk("b.stim", int'(b_if.stim), eb.stim);
        chk("b.busy", int'(b_if.busy), int'(eb.busy));
        chk("b.done", int'(b_if.done), int'(eb.done));
        chk("b.pass", int'(b_if.pass), int'(eb.pass));
        chk("b.fail_count", int'(b_if.fail_count), eb.fc);
        chk("b.first_fail_vec", int'(b_if.first_fail_vec), eb.ffv);
        chk("b.first_fail_valid", int'(b_if.first_fail_valid), int'(eb.ffvalid));
    end

    // returns at the falling edge right after the start edge (model t == 0)
    task automatic pulse_a();
        @(negedge clk) a_if.start = 1'b1;
        @(negedge clk) a_if.start = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk) b_if.start = 1'b1;
        @(negedge clk) b_if.start = 1'b0;
    endtask

    initial begin
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.stim", int'(a_if.stim), 0);
        chk("reset.done", int'(a_if.done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ideal DUT with glitches between compare edges
        a_mode = 0;
        glitch_en = 1;
        pulse_a();
        chk("ideal.busy_t0", int'(a_if.busy), 1);
        repeat (39) @(negedge clk);
        chk("ideal.busy_t39", int'(a_if.busy), 1);
        @(negedge clk);
        chk("ideal.done", int'(a_if.done), 1);
        chk("ideal.pass", int'(a_if.pass), 1);
        chk("ideal.fail_count", int'(a_if.fail_count), 0);
        chk("ideal.ffvalid", int'(a_if.first_fail_valid), 0);
        glitch_en = 0;

        a_mode = 1;
        pulse_a();
        repeat (40) @(negedge clk);
        chk("stuck0.fail_count", int'(a_if.fail_count), 4);
        chk("stuck0.ffv", int'(a_if.first_fail_vec), 0);
        chk("stuck0.ffvalid", int'(a_if.first_fail_valid), 1);
        chk("stuck0.pass", int'(a_if.pass), 0);

        a_mode = 2;
        pulse_a();
        repeat (40) @(negedge clk);
        chk("stuck1.fail_count", int'(a_if.fail_count), 4);
        chk("stuck1.ffv", int'(a_if.first_fail_vec), 1);

        a_mode = 3;
        pulse_a();
        repeat (24) @(negedge clk);
        chk("single.fc_t24", int'(a_if.fail_count), 0);
        @(negedge clk);
        chk("single.fc_t25", int'(a_if.fail_count), 1);
        chk("single.ffv", int'(a_if.first_fail_vec), 4);
        repeat (15) @(negedge clk);
        chk("single.done", int'(a_if.done), 1);
        chk("single.pass", int'(a_if.pass), 0);

        // repaired DUT restarted from DONE
        a_mode = 0;
        pulse_a();
        chk("repair.fc_cleared", int'(a_if.fail_count), 0);
        chk("repair.done_cleared", int'(a_if.done), 0);
        repeat (40) @(negedge clk);
        chk("repair.pass", int'(a_if.pass), 1);

        // start at cycle 10 of a sweep is ignored
        pulse_a();
        repeat (9) @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk) a_if.start = 1'b0;
        repeat (29) @(negedge clk);
        chk("ignore.done_t39", int'(a_if.done), 0);
        @(negedge clk);
        chk("ignore.done_t40", int'(a_if.done), 1);

        // async reset in the middle of a failing sweep
        a_mode = 1;
        pulse_a();
        repeat (16) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset.busy", int'(a_if.busy), 0);
        chk("midreset.stim", int'(a_if.stim), 0);
        chk("midreset.fail_count", int'(a_if.fail_count), 0);
        chk("midreset.ffvalid", int'(a_if.first_fail_valid), 0);
        @(negedge clk) reset = 1'b0;
        a_mode = 0;
        repeat (3) @(negedge clk);
        chk("midreset.idle_stim", int'(a_if.stim), 0);
        pulse_a();
        repeat (40) @(negedge clk);
        chk("midreset.fresh_pass", int'(a_if.pass), 1);

        // N_IN=4, SETTLE=1 instance
        b_mode = 0;
        pulse_b();
        repeat (15) @(negedge clk);
        chk("b.ideal.done_t15", int'(b_if.done), 0);
        @(negedge clk);
        chk("b.ideal.done_t16", int'(b_if.done), 1);
        chk("b.ideal.pass", int'(b_if.pass), 1);
        b_mode = 2;
        pulse_b();
        repeat (16) @(negedge clk);
        chk("b.stuck1.fail_count", int'(b_if.fail_count), 1);
        chk("b.stuck1.ffv", int'(b_if.first_fail_vec), 0);
        chk("b.stuck1.ffvalid", int'(b_if.first_fail_valid), 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
